// File: rtl/iic_arb_pkg.sv
// Shared types and constants for the camera IIC arbiter: FSM state encoding,
// requester port indices, direction constants and the latched command record.
package iic_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_LAUNCH     = 3'd1,
        ST_WAIT_START = 3'd2,
        ST_WAIT_DONE  = 3'd3,
        ST_RESP       = 3'd4
    } state_e;

    localparam logic PORT_INIT = 1'b0;
    localparam logic PORT_RT   = 1'b1;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    typedef struct packed {
        logic       mode;
        logic       rw;
        logic [7:0] slave_addr;
        logic [7:0] reg_addr_h;
        logic [7:0] reg_addr_l;
        logic [7:0] data_w;
    } cmd_t;

endpackage

// File: rtl/iic_arbiter_if.sv
// Requester-side and IIC-master-side signals of the arbiter. The slave modport is
// the arbiter's view; the master modport is the environment driving it.
interface iic_arbiter_if;
    logic [1:0] i_req;
    logic [1:0] i_rw;
    logic [1:0] i_mode;
    logic [7:0] i_slave_addr0, i_reg_addr_h0, i_reg_addr_l0, i_data_w0;
    logic [7:0] i_slave_addr1, i_reg_addr_h1, i_reg_addr_l1, i_data_w1;
    logic [1:0] o_ack;
    logic       o_err;
    logic [7:0] o_data_r;
    logic       o_busy;
    logic       o_iic_write, o_iic_read, o_iic_mode;
    logic [7:0] o_slave_addr, o_reg_addr_h, o_reg_addr_l, o_data_w;
    logic       i_iic_busy;
    logic [7:0] i_data_r;

    modport slave (
        input  i_req, i_rw, i_mode,
               i_slave_addr0, i_reg_addr_h0, i_reg_addr_l0, i_data_w0,
               i_slave_addr1, i_reg_addr_h1, i_reg_addr_l1, i_data_w1,
               i_iic_busy, i_data_r,
        output o_ack, o_err, o_data_r, o_busy, o_iic_write, o_iic_read, o_iic_mode,
               o_slave_addr, o_reg_addr_h, o_reg_addr_l, o_data_w
    );

    modport master (
        output i_req, i_rw, i_mode,
               i_slave_addr0, i_reg_addr_h0, i_reg_addr_l0, i_data_w0,
               i_slave_addr1, i_reg_addr_h1, i_reg_addr_l1, i_data_w1,
               i_iic_busy, i_data_r,
        input  o_ack, o_err, o_data_r, o_busy, o_iic_write, o_iic_read, o_iic_mode,
               o_slave_addr, o_reg_addr_h, o_reg_addr_l, o_data_w
    );
endinterface

// File: rtl/iic_arb_rr.sv
// Two-input round-robin grant; last_grant resets to the runtime port so the
// init sequencer wins the first tie.
module iic_arb_rr
    import iic_arb_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic       upd_i,
    input  logic       upd_port_i,
    output logic       valid_o,
    output logic       port_o
);
    logic last_q, last_d;

    always_comb begin
        last_d = last_q;
        if (upd_i) last_d = upd_port_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) last_q <= PORT_RT;
        else         last_q <= last_d;
    end

    always_comb begin
        valid_o = |req_i;
        case (req_i)
            2'b10:   port_o = PORT_RT;
            2'b11:   port_o = ~last_q;
            default: port_o = PORT_INIT;
        endcase
    end
endmodule

// File: rtl/iic_arbiter.sv
// Two-port arbiter/sequencer in front of the camera IIC master: grant, strobe,
// track active-low busy, ack. Optional transfer timeout under IIC_ARB_TIMEOUT_EN.
module iic_arbiter
    import iic_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000,
    parameter int unsigned CNT_W          = 21
) (
    input logic          i_clk,
    input logic          i_rst,
    iic_arbiter_if.slave bus
);
    state_e     state_q, state_d;
    cmd_t       cmd_q, cmd_d, cmd_p0, cmd_p1;
    logic       port_q, port_d;
    logic [1:0] ack_q, ack_d;
    logic [7:0] data_r_q, data_r_d;
    logic       busy_q, busy_d, wr_q, wr_d, rd_q, rd_d;
    logic       gnt_valid, gnt_port, rr_upd;

`ifdef IIC_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`endif

    assign cmd_p0 = '{mode: bus.i_mode[0], rw: bus.i_rw[0], slave_addr: bus.i_slave_addr0,
                      reg_addr_h: bus.i_reg_addr_h0, reg_addr_l: bus.i_reg_addr_l0,
                      data_w: bus.i_data_w0};
    assign cmd_p1 = '{mode: bus.i_mode[1], rw: bus.i_rw[1], slave_addr: bus.i_slave_addr1,
                      reg_addr_h: bus.i_reg_addr_h1, reg_addr_l: bus.i_reg_addr_l1,
                      data_w: bus.i_data_w1};

    iic_arb_rr u_rr (
        .clk_i      (i_clk),
        .rst_ni     (i_rst),
        .req_i      (bus.i_req),
        .upd_i      (rr_upd),
        .upd_port_i (port_q),
        .valid_o    (gnt_valid),
        .port_o     (gnt_port)
    );

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path infers a latch.
        state_d  = state_q;
        cmd_d    = cmd_q;
        port_d   = port_q;
        ack_d    = 2'b00;
        data_r_d = data_r_q;
        rr_upd   = 1'b0;
`ifdef IIC_ARB_TIMEOUT_EN
        err_d    = 1'b0;
        cnt_d    = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.i_iic_busy && gnt_valid) begin
                    port_d  = gnt_port;
                    cmd_d   = (gnt_port == PORT_RT) ? cmd_p1 : cmd_p0;
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                state_d = ST_WAIT_START;
`ifdef IIC_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            ST_WAIT_START: begin
                if (!bus.i_iic_busy) state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (bus.i_iic_busy) begin
                    state_d       = ST_RESP;
                    ack_d[port_q] = 1'b1;
                    data_r_d      = (cmd_q.rw == RW_READ) ? bus.i_data_r : 8'h00;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                rr_upd  = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
`ifdef IIC_ARB_TIMEOUT_EN
        // A genuine completion in the same cycle as the deadline is reported as success.
        if (state_q == ST_WAIT_START || state_q == ST_WAIT_DONE) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_d == CNT_W'(TIMEOUT_CYCLES) && state_d != ST_RESP) begin
                state_d       = ST_RESP;
                ack_d[port_q] = 1'b1;
                err_d         = 1'b1;
                data_r_d      = 8'h00;
            end
        end
`endif
        busy_d = (state_d != ST_IDLE);
        wr_d   = (state_d == ST_LAUNCH || state_d == ST_WAIT_START) && (cmd_d.rw == RW_WRITE);
        rd_d   = (state_d == ST_LAUNCH || state_d == ST_WAIT_START) && (cmd_d.rw == RW_READ);
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q  <= ST_IDLE;
            cmd_q    <= '0;
            port_q   <= PORT_INIT;
            ack_q    <= 2'b00;
            data_r_q <= 8'h00;
            busy_q   <= 1'b0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
`ifdef IIC_ARB_TIMEOUT_EN
            cnt_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            port_q   <= port_d;
            ack_q    <= ack_d;
            data_r_q <= data_r_d;
            busy_q   <= busy_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
`ifdef IIC_ARB_TIMEOUT_EN
            cnt_q    <= cnt_d;
            err_q    <= err_d;
`endif
        end
    end

`ifdef IIC_ARB_TIMEOUT_EN
    assign bus.o_err = err_q;
`else
    logic unused_cfg;
    assign unused_cfg = ^{TIMEOUT_CYCLES, CNT_W};
    assign bus.o_err  = 1'b0;
`endif

    assign bus.o_ack        = ack_q;
    assign bus.o_data_r     = data_r_q;
    assign bus.o_busy       = busy_q;
    assign bus.o_iic_write  = wr_q;
    assign bus.o_iic_read   = rd_q;
    assign bus.o_iic_mode   = cmd_q.mode;
    assign bus.o_slave_addr = cmd_q.slave_addr;
    assign bus.o_reg_addr_h = cmd_q.reg_addr_h;
    assign bus.o_reg_addr_l = cmd_q.reg_addr_l;
    assign bus.o_data_w     = cmd_q.data_w;
endmodule

// File: tb/tb_iic_arbiter.sv
// Directed bench for iic_arbiter with a small IIC master model (busy low after a
// delay, held for a programmable time). Timeout scenario runs with IIC_ARB_TIMEOUT_EN.
module tb_iic_arbiter;
    logic clk;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;

    iic_arbiter_if bus ();

    iic_arbiter #(
        .TIMEOUT_CYCLES (100),
        .CNT_W          (7)
    ) dut (
        .i_clk (clk),
        .i_rst (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Master model knobs (written by the sequence) and its own outputs.
    logic       m_en = 1'b1;
    int         m_delay = 3;
    int         m_hold = 50;
    logic [7:0] m_data = 8'h00;
    logic       m_busy;
    logic [7:0] m_rdata;
    logic       hold_low = 1'b0;
    int         ack0_cnt = 0;

    assign bus.i_iic_busy = m_busy & ~hold_low;
    assign bus.i_data_r   = m_rdata;

    initial begin
        m_busy  = 1'b1;
        m_rdata = 8'h00;
        forever begin
            @(posedge clk); #1;
            if (m_en && (bus.o_iic_write || bus.o_iic_read)) begin
                repeat (m_delay) begin @(posedge clk); #1; end
                m_busy = 1'b0;
                repeat (m_hold) begin @(posedge clk); #1; end
                m_rdata = m_data;
                m_busy  = 1'b1;
            end
        end
    end

    always @(negedge clk) if (bus.o_ack[0]) ack0_cnt++;

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return {17'd0, bus.o_ack, bus.o_err, bus.o_data_r, bus.o_busy, bus.o_iic_write,
                bus.o_iic_read, bus.o_iic_mode, bus.o_slave_addr, bus.o_reg_addr_h,
                bus.o_reg_addr_l, bus.o_data_w};
    endfunction

    task automatic wait_ack(input string tag, input int budget, output int cyc);
        cyc = 0;
        while (bus.o_ack == 2'b00 && cyc < budget) begin tick(1); cyc++; end
        check({tag, "_ack_seen"}, 64'(bus.o_ack != 2'b00), 64'd1);
    endtask

    task automatic wait_strobe(input string tag, input int budget, output int cyc);
        cyc = 0;
        while (!(bus.o_iic_write || bus.o_iic_read) && cyc < budget) begin tick(1); cyc++; end
        check({tag, "_strobe_seen"}, 64'(bus.o_iic_write | bus.o_iic_read), 64'd1);
    endtask

    task automatic set_port0(input logic [7:0] sa, input logic [15:0] ra, input logic [7:0] d,
                             input logic rw, input logic mode);
        bus.i_slave_addr0 = sa; bus.i_reg_addr_h0 = ra[15:8]; bus.i_reg_addr_l0 = ra[7:0];
        bus.i_data_w0 = d; bus.i_rw[0] = rw; bus.i_mode[0] = mode;
    endtask

    task automatic set_port1(input logic [7:0] sa, input logic [15:0] ra, input logic [7:0] d,
                             input logic rw, input logic mode);
        bus.i_slave_addr1 = sa; bus.i_reg_addr_h1 = ra[15:8]; bus.i_reg_addr_l1 = ra[7:0];
        bus.i_data_w1 = d; bus.i_rw[1] = rw; bus.i_mode[1] = mode;
    endtask

    initial begin
        int cyc;
        int snap;
        rst_n      = 1'b1;
        bus.i_req  = 2'b00;
        bus.i_rw   = 2'b00;
        bus.i_mode = 2'b00;
        set_port0(8'h00, 16'h0000, 8'h00, 1'b0, 1'b0);
        set_port1(8'h00, 16'h0000, 8'h00, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        tick(2);
        check("reset_outputs", outs(), 64'd0);
        rst_n = 1'b1;
        tick(2);
        check("idle_outputs", outs(), 64'd0);

        // Single write on port 0: slave 0x6C, reg 0x0100, data 0x01.
        m_delay = 3; m_hold = 50; m_data = 8'hAA;
        set_port0(8'h6C, 16'h0100, 8'h01, 1'b0, 1'b1);
        bus.i_req = 2'b01;
        tick(1);
        check("wr_launch_write", 64'(bus.o_iic_write), 64'd1);
        check("wr_launch_read", 64'(bus.o_iic_read), 64'd0);
        check("wr_launch_busy", 64'(bus.o_busy), 64'd1);
        check("wr_fields", {bus.o_iic_mode, bus.o_slave_addr, bus.o_reg_addr_h, bus.o_reg_addr_l, bus.o_data_w},
              {1'b1, 8'h6C, 8'h01, 8'h00, 8'h01});
        tick(3);
        check("wr_strobe_held", 64'(bus.o_iic_write), 64'd1);
        tick(1);
        check("wr_strobe_dropped", 64'(bus.o_iic_write), 64'd0);
        check("wr_busy_wait_done", 64'(bus.o_busy), 64'd1);
        wait_ack("wr", 100, cyc);
        check("wr_ack_latency", 64'(cyc), 64'd50);
        check("wr_ack", 64'(bus.o_ack), 64'd1);
        check("wr_err", 64'(bus.o_err), 64'd0);
        check("wr_data_r_zero", 64'(bus.o_data_r), 64'd0);
        check("wr_busy_resp", 64'(bus.o_busy), 64'd1);
        bus.i_req = 2'b00;
        tick(1);
        check("wr_ack_once", 64'(bus.o_ack), 64'd0);
        check("wr_busy_idle", 64'(bus.o_busy), 64'd0);

        // Read on port 1 of reg 0x300A; model returns 0x56.
        m_hold = 10; m_data = 8'h56;
        set_port1(8'h6C, 16'h300A, 8'h00, 1'b1, 1'b1);
        bus.i_req = 2'b10;
        tick(1);
        check("rd_strobe", {bus.o_iic_read, bus.o_iic_write}, 2'b10);
        check("rd_reg", {bus.o_reg_addr_h, bus.o_reg_addr_l}, 16'h300A);
        wait_ack("rd", 100, cyc);
        check("rd_ack_latency", 64'(cyc), 64'd14);
        check("rd_ack", 64'(bus.o_ack), 64'd2);
        check("rd_data", 64'(bus.o_data_r), 64'h56);
        check("rd_err", 64'(bus.o_err), 64'd0);
        bus.i_req = 2'b00;
        tick(1);

        // Tie: both ports keep requesting; expect grants 0,1,0,1.
        m_hold = 5; m_data = 8'h00;
        set_port0(8'h10, 16'h0011, 8'h22, 1'b0, 1'b0);
        set_port1(8'h20, 16'h0033, 8'h44, 1'b0, 1'b0);
        bus.i_req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            logic [7:0] exp_sa;
            logic [1:0] exp_ack;
            exp_sa  = (i % 2 == 0) ? 8'h10 : 8'h20;
            exp_ack = (i % 2 == 0) ? 2'b01 : 2'b10;
            wait_strobe($sformatf("tie%0d", i), 20, cyc);
            check($sformatf("tie%0d_slave", i), 64'(bus.o_slave_addr), 64'(exp_sa));
            wait_ack($sformatf("tie%0d", i), 50, cyc);
            check($sformatf("tie%0d_ack", i), 64'(bus.o_ack), 64'(exp_ack));
            if (i == 3) bus.i_req = 2'b00;
            tick(1);
            check($sformatf("tie%0d_idle_gap", i), 64'(bus.o_busy), 64'd0);
        end

        // Master busy when port 0 requests: no strobe until busy returns.
        hold_low = 1'b1;
        set_port0(8'h6C, 16'h0100, 8'h02, 1'b0, 1'b1);
        bus.i_req = 2'b01;
        tick(5);
        check("mb_no_strobe", {bus.o_iic_write, bus.o_busy}, 2'b00);
        hold_low = 1'b0;
        tick(1);
        check("mb_strobe_after", 64'(bus.o_iic_write), 64'd1);
        wait_ack("mb", 50, cyc);
        check("mb_ack", 64'(bus.o_ack), 64'd1);
        bus.i_req = 2'b00;
        tick(1);

`ifdef IIC_ARB_TIMEOUT_EN
        // Master never responds: ack 101 cycles after the strobe with err set.
        m_en = 1'b0;
        set_port1(8'h6C, 16'h3500, 8'h10, 1'b0, 1'b1);
        bus.i_req = 2'b10;
        tick(1);
        check("to_strobe", 64'(bus.o_iic_write), 64'd1);
        wait_ack("to", 200, cyc);
        check("to_latency", 64'(cyc), 64'd101);
        check("to_ack", 64'(bus.o_ack), 64'd2);
        check("to_err", 64'(bus.o_err), 64'd1);
        check("to_data_r", 64'(bus.o_data_r), 64'd0);
        check("to_strobe_dropped", 64'(bus.o_iic_write), 64'd0);
        bus.i_req = 2'b00;
        tick(1);
        check("to_err_clears", 64'(bus.o_err), 64'd0);
        m_en = 1'b1;
`endif

        // Reset during WAIT_DONE: outputs clear at once, no ack; then a fresh request.
        m_delay = 3; m_hold = 30;
        snap = ack0_cnt;
        set_port0(8'h6C, 16'h0202, 8'h03, 1'b0, 1'b1);
        bus.i_req = 2'b01;
        tick(1);
        check("rst_strobe", 64'(bus.o_iic_write), 64'd1);
        tick(6);
        check("rst_in_wait_done", {bus.o_busy, bus.o_iic_write}, 2'b10);
        rst_n = 1'b0;
        bus.i_req = 2'b00;
        #1;
        check("rst_async_clear", outs(), 64'd0);
        tick(2);
        rst_n = 1'b1;
        set_port1(8'h42, 16'h0101, 8'h05, 1'b0, 1'b1);
        bus.i_req = 2'b10;
        wait_strobe("post_rst", 100, cyc);
        check("post_rst_wait_busy", 64'(cyc), 64'd26);
        check("post_rst_slave", 64'(bus.o_slave_addr), 64'h42);
        wait_ack("post_rst", 100, cyc);
        check("post_rst_ack", 64'(bus.o_ack), 64'd2);
        bus.i_req = 2'b00;
        tick(1);
        check("rst_no_port0_ack", 64'(ack0_cnt), 64'(snap));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/iic_arbiter.md
# iic_arbiter

Two-port arbiter and sequencer in front of the camera IIC master (`Driver_IIC`). It lets the OV5647 power-up sequencer and a runtime register-access client (exposure and gain tuning, register readback) share one IIC master. It latches the granted command and produces the rising-edge write or read strobe the master expects. It then tracks the master's active-low busy line through one transfer and returns a one-cycle acknowledge, with read data, to the granted requester. It sits on `clk_100MHz_system`, between the requesters and `Driver_IIC`.

## Interface
- `TIMEOUT_CYCLES`, default 2_000_000: cycles allowed from strobe assertion to end of transfer, 20 ms at 100 MHz.
- `CNT_W`, default 21: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- `i_clk` in 1: system clock, 100 MHz.
- `i_rst` in 1: asynchronous, active-low reset.
- `i_req[1:0]` in 2: per-port request level. Port 0 is the init sequencer, port 1 is the runtime client.
- `i_rw[1:0]` in 2: per-port direction, 1 = read, 0 = write.
- `i_mode[1:0]` in 2: per-port address mode, 1 = 16-bit register address, 0 = 8-bit (low byte only).
- `i_slave_addr0`, `i_reg_addr_h0`, `i_reg_addr_l0`, `i_data_w0` in 8 each: port 0 command fields.
- `i_slave_addr1`, `i_reg_addr_h1`, `i_reg_addr_l1`, `i_data_w1` in 8 each: port 1 command fields.
- `o_ack[1:0]` out 2: one-cycle completion pulse per port.
- `o_err` out 1: valid with `o_ack`; 1 = transfer timed out.
- `o_data_r` out 8: read data, valid with `o_ack`.
- `o_busy` out 1: 1 while the arbiter owns the IIC master.
- `o_iic_write`, `o_iic_read` out 1: strobes to the master.
- `o_iic_mode` out 1, `o_slave_addr`, `o_reg_addr_h`, `o_reg_addr_l`, `o_data_w` out 8: latched command fields.
- `i_iic_busy` in 1: master busy, active-low (0 = transfer in progress).
- `i_data_r` in 8: master read data.

## Operation
- States: IDLE, LAUNCH, WAIT_START, WAIT_DONE, RESP.
- **IDLE:**
  - Grant is allowed only when `i_iic_busy`=1 and some `i_req` bit is set.
  - If exactly one port requests, that port is granted.
  - If both request, round-robin: the port not granted last wins. `last_grant` resets to 1, so port 0 wins the first tie.
  - On grant: latch all fields of the granted port, record the port index, go to LAUNCH.
- **LAUNCH:**
  - Assert `o_iic_write` (`rw`=0) or `o_iic_read` (`rw`=1). Clear the timeout counter.
  - Next state is WAIT_START.
- **WAIT_START:**
  - Hold the strobe high until `i_iic_busy`=0.
  - Then drop the strobe and go to WAIT_DONE.
- **WAIT_DONE:**
  - Wait for `i_iic_busy`=1. Capture `i_data_r` and go to RESP.
- **RESP:**
  - Pulse `o_ack[grant]` for one cycle with `o_err`=0 and `o_data_r` valid.
  - Update `last_grant`. Return to IDLE.
- Command fields stay stable from LAUNCH through RESP. Requester inputs are ignored after grant.
- Requester handshake:
  - Hold `i_req` and all fields until `o_ack`.
  - Deassert `i_req` in the cycle after `o_ack`. The arbiter does not sample `i_req` in RESP, so a request still high in the following IDLE cycle is treated as a new transaction.
- Write transfers: `o_data_r` = 0 at ack.
- 8-bit mode: `o_reg_addr_h` is passed through unchanged; the master ignores it.

## Timing
- Reset values:
  - Outputs: all 0, including `o_ack`, `o_err`, `o_busy`, both strobes and all fields.
  - Internal: state IDLE, `last_grant`=1, counter 0.
- Reset asserted mid-transfer:
  - Outputs clear immediately (asynchronous); no ack is issued.
  - After release, grants wait for `i_iic_busy`=1 as usual.
- All outputs are registered.
  - Grant at IDLE cycle N gives strobe and `o_busy` high at N+1.
  - The strobe drops one cycle after `i_iic_busy` is sampled 0.
  - `o_ack` rises one cycle after `i_iic_busy` is sampled back at 1.
- Minimum request-to-ack latency: 4 cycles plus the master busy time.
- `o_busy` is high from LAUNCH through RESP inclusive.
- Simultaneous new request and RESP: the request waits until the next IDLE cycle, so there is at least one idle cycle between transfers.

## Configuration
- Macro `IIC_ARB_TIMEOUT_EN`.
- Defined:
  - The counter runs in WAIT_START and WAIT_DONE.
  - When the counter reaches `TIMEOUT_CYCLES`: drop the strobe, go to RESP, and ack with `o_err`=1 and `o_data_r`=0.
  - The arbiter then waits in IDLE until `i_iic_busy`=1 before any further grant.
- Undefined:
  - No counter; the arbiter waits indefinitely.
  - `o_err` is tied 0.
  - `TIMEOUT_CYCLES` and `CNT_W` are unused.

## Structure
- Shared package `iic_arb_pkg` holds:
  - the state encoding (IDLE=0 … RESP=4);
  - port index constants `PORT_INIT`=0 and `PORT_RT`=1;
  - the direction constants.
- One sub-module, `iic_arb_rr`: the two-input round-robin grant with the `last_grant` register.
- The FSM, command latch and timeout counter live in `iic_arbiter`.

## Test plan
- **Single write:** port 0 write (slave 0x6C, reg 0x0100, data 0x01). The bench master pulls busy low 3 cycles after the strobe and holds it 50 cycles.
  - Required: strobe high until busy is sampled low; `o_ack`=2'b01 exactly once, `o_err`=0.
- **Read:** port 1 read of reg 0x300A; the model returns 0x56.
  - Required: `o_iic_read` pulse; `o_ack`=2'b10 with `o_data_r`=0x56.
- **Tie:** both ports request in the same cycle, then again after each ack.
  - Required: grant order 0, 1, 0, 1, checked via `o_slave_addr` per port.
- **Master busy at request:** `i_iic_busy`=0 when port 0 requests.
  - Required: no strobe until busy returns to 1.
- **Timeout (`IIC_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=100):** the master never asserts busy.
  - Required: ack at cycle 101 after the strobe, with `o_err`=1 and `o_data_r`=0.
- **Mid-transfer reset:** `i_rst` pulled low during WAIT_DONE.
  - Required: all outputs 0 immediately and no ack. After release and busy=1, a new request completes normally.
